fifo_to_com: RTL and testbench
==============================

Name: fifo_to_com

Overview:
Downstream drain stage for the COM receive path. It pops bytes from the byte FIFO and serialises them onto a UART TX line (8N1, LSB first). It keeps a running serial CRC8 over every byte sent. On request it appends the CRC byte as a frame trailer, then clears the CRC for the next frame.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range >= 2
CRC_POLY, 8'h07, CRC8 polynomial (x^8+x^2+x+1)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
enable  input  1  when high, the block may start a new byte
fifo_empty  input  1  FIFO has no data
fifo_data_in  input  8  FIFO read data; valid the cycle after fifo_re
fifo_re  output  1  one-cycle FIFO pop strobe
send_crc  input  1  pulse: append CRC trailer once the FIFO has drained
tx  output  1  UART serial out; idle high
busy  output  1  high in every state except IDLE
isFinish  output  1  one-cycle pulse after the CRC trailer's stop bit
CRC  output  8  running CRC8 of data bytes sent since the last trailer
state  output  3  current FSM state, for debug

Behaviour:
- Reset (reset=0, async): state=IDLE(0), tx=1, fifo_re=0, busy=0, isFinish=0, CRC=8'h00, crc_req=0, bit counter and baud counter cleared. A reset mid-frame drives tx high immediately.
- crc_req: sticky flag. Set on any cycle with send_crc=1, in any state. Cleared when the trailer enters SEND.
- IDLE(0):
  - If enable=1 and fifo_empty=0: go to READ.
  - Else if enable=1 and crc_req=1: load shifter with CRC, mark trailer, go to SEND.
  - Data has priority over the trailer. The trailer is sent only when the FIFO is empty.
- READ(1): fifo_re=1 for exactly this cycle, then go to LATCH.
- LATCH(2): capture fifo_data_in into the shifter and a byte register, then go to CRCCALC.
- CRCCALC(3): 8 cycles, MSB first.
  - Per bit: fb = CRC[7] ^ bit; CRC <= {CRC[6:0],1'b0} ^ (fb ? CRC_POLY : 8'h00).
  - Then go to SEND.
  - Trailer bytes are never fed into the CRC.
- SEND(4): 10 bit-times (start 0, d0..d7, stop 1), each held exactly CLKS_PER_BIT cycles.
  - After the stop bit, go to IDLE for a data byte, or to DONE for the trailer.
- DONE(5): isFinish=1 for one cycle, CRC<=8'h00, go to IDLE.
- Latency for a data byte: IDLE seeing !fifo_empty at cycle 0 gives fifo_re at cycle 1 and the start bit from cycle 11.
- Back-to-back bytes: at least 1 idle-high cycle between the stop bit and the next start bit. There is no gap larger than 11 cycles when the FIFO stays non-empty.
- enable dropped mid-byte: the current byte (or trailer) completes; no new byte starts.
- fifo_empty rising while in READ/LATCH is ignored; the strobe has already been issued.
- fifo_re is never asserted while fifo_empty=1 in IDLE.
- send_crc with no data bytes since the last trailer: trailer 8'h00 is sent.
- States 6 and 7 are unreachable; if entered, go to IDLE with tx=1.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: tx=1, busy=0, fifo_re=0, CRC=00 for 100 cycles.
- Single byte: FIFO holds 8'h31, enable=1 -> one fifo_re pulse; tx sends 0,1,0,0,0,1,1,0,0,1 at 4 cycles/bit starting 11 cycles after fifo_re's predecessor cycle; CRC=8'h97 afterwards.
- ASCII "123456789" then send_crc pulse -> 9 data frames then trailer frame 8'hF4; isFinish pulses once; CRC returns to 00.
- send_crc asserted while 3 bytes are still queued -> all 3 data bytes are sent first, then exactly one trailer.
- enable deasserted mid-frame -> frame completes with a correct stop bit; no further fifo_re until enable=1.
- Async reset during the d3 bit -> tx=1 on the same edge, state=0, CRC=00; the next byte transmits cleanly.

Source files
------------

// File: rtl/fifo_to_com.sv
// Drains the byte FIFO onto an 8N1 UART TX line, keeps a serial CRC8 over the
// data bytes sent, and appends that CRC as a frame trailer on request.
module fifo_to_com #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [7:0]  CRC_POLY     = 8'h07
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data_in,
  output logic       fifo_re,
  input  logic       send_crc,
  output logic       tx,
  output logic       busy,
  output logic       isFinish,
  output logic [7:0] CRC,
  output logic [2:0] state
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  STOP_IDX  = BIT_W'(9);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(8);
  localparam logic [BIT_W-1:0]  CRC_LAST  = BIT_W'(7);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    LATCH    = 3'd2,
    CRC_CALC = 3'd3,
    SEND     = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                tx_q, tx_d;
  logic                fifo_re_q, fifo_re_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic [7:0]          crc_q, crc_d;
  logic                crc_req_q, crc_req_d;
  logic                trailer_q, trailer_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;

  logic [2:0]          crc_idx;
  logic                crc_fb;
  logic [7:0]          crc_step;

  // State and datapath registers; reset parks the line high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      fifo_re_q <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      crc_q     <= 8'h00;
      crc_req_q <= 1'b0;
      trailer_q <= 1'b0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      bit_q     <= '0;
      baud_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      fifo_re_q <= fifo_re_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
      crc_q     <= crc_d;
      crc_req_q <= crc_req_d;
      trailer_q <= trailer_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_q     <= bit_d;
      baud_q    <= baud_d;
    end
  end

  // One CRC8 step over the latched byte, MSB first
  always_comb begin
    crc_idx  = 3'd7 - bit_q[2:0];
    crc_fb   = crc_q[7] ^ data_q[crc_idx];
    crc_step = {crc_q[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    crc_d     = crc_q;
    crc_req_d = crc_req_q | send_crc;
    trailer_d = trailer_q;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_d     = bit_q;
    baud_d    = baud_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo_empty) begin
          state_d = READ;
        end else if (enable && crc_req_q) begin
          // Trailer only goes out once the FIFO has drained
          shift_d   = crc_q;
          trailer_d = 1'b1;
          crc_req_d = send_crc;
          bit_d     = '0;
          baud_d    = '0;
          tx_d      = 1'b0;
          state_d   = SEND;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d   = fifo_data_in;
        data_d    = fifo_data_in;
        trailer_d = 1'b0;
        bit_d     = '0;
        state_d   = CRC_CALC;
      end
      CRC_CALC: begin
        crc_d = crc_step;
        if (bit_q == CRC_LAST) begin
          bit_d   = '0;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = SEND;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_IDX) begin
            tx_d    = 1'b1;
            state_d = trailer_q ? DONE : IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            // bit_q counts the bit just finished: 0 start, 1..8 data
            if (bit_q < DATA_LAST) begin
              tx_d    = shift_q[0];
              shift_d = {1'b0, shift_q[7:1]};
            end else begin
              tx_d = 1'b1;
            end
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DONE: begin
        crc_d     = 8'h00;
        trailer_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    fifo_re_d = (state_d == READ);
    busy_d    = (state_d != IDLE);
    fin_d     = (state_d == DONE);
  end

  assign fifo_re  = fifo_re_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign isFinish = fin_q;
  assign CRC      = crc_q;
  assign state    = state_q;

endmodule

// File: tb/tb_fifo_to_com.sv
// Scoreboard bench for fifo_to_com: stimulus queues expected UART bytes, a
// monitor decodes tx frames and pops/compares them.
module tb_fifo_to_com;

  localparam int unsigned CPB = 4;

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic       enable       = 1'b0;
  logic       fifo_empty   = 1'b1;
  logic [7:0] fifo_data_in = 8'h00;
  logic       send_crc     = 1'b0;
  logic       fifo_re;
  logic       tx;
  logic       busy;
  logic       isFinish;
  logic [7:0] CRC;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int fin_cnt = 0;
  int re_cnt = 0;
  int pop_empty_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  fifo_to_com #(.CLKS_PER_BIT(CPB), .CRC_POLY(8'h07)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_in(fifo_data_in), .fifo_re(fifo_re), .send_crc(send_crc),
    .tx(tx), .busy(busy), .isFinish(isFinish), .CRC(CRC), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (fifo_re) begin
      if (fifo_q.size() == 0) pop_empty_cnt++;
      else fifo_data_in <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (isFinish) fin_cnt++;
    if (fifo_re) re_cnt++;
  end

  task automatic mon_wait(input int n, inout bit ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!reset) ab = 1'b1;
    end
  endtask

  // Frame monitor: sample each bit mid-cell, drop frames cut by reset
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    logic       st;
    logic       sb;
    bit         ab;
    b = 8'h00;
    forever begin
      @(negedge tx);
      ab = !reset;
      mon_wait(2, ab);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        mon_wait(4, ab);
        b[i] = tx;
      end
      mon_wait(4, ab);
      sb = tx;
      if (!ab) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got byte 0x%02h, required no frame", b);
        end else begin
          e = exp_q.pop_front();
          check("frame_start", 32'(st), 32'd0);
          check("frame_data", 32'(b), 32'(e));
          check("frame_stop", 32'(sb), 32'd1);
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_it);
    fifo_q.push_back(b);
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic pulse_crc();
    send_crc = 1'b1;
    @(negedge clk);
    send_crc = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy || !fifo_empty || fifo_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required drained", name, n);
    end
  endtask

  task automatic wait_tx_low(input string name, input int max_cyc);
    int n = 0;
    while (tx && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s: tx still high after %0d cycles, required start bit", name, n);
    end
  endtask

  initial begin : stim
    int n;
    int r0;
    int f0;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_re", 32'(fifo_re), 32'd0);
    check("rst_isFinish", 32'(isFinish), 32'd0);
    check("rst_crc", 32'(CRC), 32'h00);
    check("rst_state", 32'(state), 32'd0);
    reset  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_fifo_re", 32'(fifo_re), 32'd0);
      check("idle_crc", 32'(CRC), 32'h00);
    end

    // Single byte 0x31: latency, one pop, CRC 0x97
    r0 = re_cnt;
    push(8'h31, 1'b1);
    n = 0;
    while (fifo_empty && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!fifo_re && n < 20) begin @(negedge clk); n++; end
    check("lat_fifo_re", 32'(n), 32'd1);
    while (tx && n < 40) begin @(negedge clk); n++; end
    check("lat_start_bit", 32'(n), 32'd11);
    check("send_state", 32'(state), 32'd4);
    wait_drain("drain_single", 200);
    check("crc_single", 32'(CRC), 32'h97);
    check("re_single", 32'(re_cnt - r0), 32'd1);

    // Trailer for the single byte
    f0 = fin_cnt;
    exp_q.push_back(8'h97);
    pulse_crc();
    wait_drain("drain_trailer_31", 200);
    check("fin_trailer_31", 32'(fin_cnt - f0), 32'd1);
    check("crc_clear_31", 32'(CRC), 32'h00);

    // "123456789" then trailer 0xF4
    for (int i = 0; i < 9; i++) push(8'(8'h31 + i), 1'b1);
    wait_drain("drain_123456789", 1000);
    check("crc_123456789", 32'(CRC), 32'hF4);
    f0 = fin_cnt;
    exp_q.push_back(8'hF4);
    pulse_crc();
    wait_drain("drain_trailer_f4", 200);
    check("fin_trailer_f4", 32'(fin_cnt - f0), 32'd1);
    check("crc_clear_f4", 32'(CRC), 32'h00);

    // send_crc while bytes are still queued: data first, one trailer
    f0 = fin_cnt;
    r0 = re_cnt;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h43, 1'b1);
    exp_q.push_back(8'h52);
    pulse_crc();
    wait_drain("drain_abc", 1000);
    repeat (60) @(negedge clk);
    check("fin_abc", 32'(fin_cnt - f0), 32'd1);
    check("re_abc", 32'(re_cnt - r0), 32'd3);
    check("crc_clear_abc", 32'(CRC), 32'h00);

    // enable dropped mid-frame
    r0 = re_cnt;
    push(8'h5A, 1'b1);
    push(8'hA5, 1'b1);
    wait_tx_low("en_off_start", 40);
    enable = 1'b0;
    repeat (250) @(negedge clk);
    check("en_off_re", 32'(re_cnt - r0), 32'd1);
    check("en_off_pending", 32'(exp_q.size()), 32'd1);
    check("en_off_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_drain("drain_en_on", 200);
    check("en_on_re", 32'(re_cnt - r0), 32'd2);

    // Async reset during d3 of 0x34 (d3 = 0)
    push(8'h34, 1'b0);
    wait_tx_low("rst_frame_start", 40);
    repeat (16) @(negedge clk);
    check("pre_rst_d3", 32'(tx), 32'd0);
    #1 reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_crc", 32'(CRC), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    push(8'hC3, 1'b1);
    wait_drain("drain_after_rst", 200);
    check("crc_after_rst", 32'(CRC), 32'h47);
    f0 = fin_cnt;
    exp_q.push_back(8'h47);
    pulse_crc();
    wait_drain("drain_trailer_47", 200);
    check("fin_trailer_47", 32'(fin_cnt - f0), 32'd1);
    check("crc_clear_47", 32'(CRC), 32'h00);

    check("fifo_pop_on_empty", 32'(pop_empty_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
